// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states, MMIO offsets.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] OFF_TOHOST = 32'd0;
  localparam logic [31:0] OFF_CYCLE  = 32'd4;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_H) && addr_lo[0]) || ((size == SZ_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte-enables/data replication and
// load lane selection with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  wr_be_o,
  output logic [31:0] wr_data_o,
  output logic [31:0] rd_data_o
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign wr_be_o[gi] = (size_i == SZ_W) ||
                           ((size_i == SZ_H) && (addr_lo_i[1] == LANE[1])) ||
                           ((size_i == SZ_B) && (addr_lo_i == LANE));
      assign wr_data_o[8*gi +: 8] = (size_i == SZ_B) ? wdata_i[7:0] :
                                    (size_i == SZ_H) ? wdata_i[8*(gi%2) +: 8] :
                                                       wdata_i[8*gi +: 8];
    end
  endgenerate

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = rword_i >> {addr_lo_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SZ_B:    rd_data_o = {{24{byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_H:    rd_data_o = {{16{half_sel[15] & ~unsigned_i}}, half_sel};
      default: rd_data_o = rword_i;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with valid/ready request and response channels.
// Optional MMIO window (tohost, cycle counter) is compiled in when DMEM_MMIO_EN is defined.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        halt,
  output logic [31:0] tohost
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        err_q, load_q;
  logic [31:0] mem_rd_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, access, req_err, in_mmio, out_of_range, mem_we;
  logic [IDX_W-1:0] idx;
  logic [3:0]       wr_be;
  logic [31:0]      wr_data, rd_data, rword;

  assign idx          = addr_q[IDX_W+1:2];
  assign out_of_range = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS)) && !in_mmio;
  assign req_err      = (size_q == 2'd3) || is_misaligned(size_q, addr_q[1:0]) ||
                        out_of_range || (in_mmio && (size_q != SZ_W));

  // The first WAIT cycle judges the latched request; errors leave immediately,
  // otherwise the counter runs down the remaining wait states before the access.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (req_err) begin
          cnt_d   = 4'd0;
          state_d = ST_RESP;
        end else if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wen_q   <= req_wen;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        err_q   <= 1'b0;
        load_q  <= 1'b0;
      end
      if ((state_q == ST_WAIT) && (state_d == ST_RESP)) begin
        err_q  <= req_err;
        load_q <= !req_err && !wen_q;
      end
    end
  end

  // Store is gated by reset so an access edge coinciding with reset never commits.
  assign mem_we = access && wen_q && !in_mmio && reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
    if (access && !wen_q) mem_rd_q <= mem[idx];
  end

`ifdef DMEM_MMIO_EN
  logic [31:0] win_off, tohost_q, cycle_q, mmio_rd_q;
  logic        halt_q, mmio_q;

  assign win_off = addr_q - MMIO_BASE;
  assign in_mmio = win_off < 32'd8;

  always_ff @(posedge clk) begin
    if (!reset) begin
      tohost_q  <= 32'd0;
      halt_q    <= 1'b0;
      cycle_q   <= 32'd0;
      mmio_q    <= 1'b0;
      mmio_rd_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (accept) mmio_q <= 1'b0;
      if (access) begin
        mmio_q    <= in_mmio;
        mmio_rd_q <= (win_off == OFF_CYCLE) ? cycle_q : tohost_q;
        if (in_mmio && wen_q && (win_off == OFF_TOHOST)) begin
          tohost_q <= wdata_q;
          if (wdata_q != 32'd0) halt_q <= 1'b1;
        end
      end
    end
  end

  assign rword  = mmio_q ? mmio_rd_q : mem_rd_q;
  assign halt   = halt_q;
  assign tohost = tohost_q;
`else
  logic unused_mmio_base;
  assign unused_mmio_base = ^MMIO_BASE;
  assign in_mmio = 1'b0;
  assign rword   = mem_rd_q;
  assign halt    = 1'b0;
  assign tohost  = 32'd0;
`endif

  dmem_lane_align u_align (
    .addr_lo_i  (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .wr_be_o    (wr_be),
    .wr_data_o  (wr_data),
    .rd_data_o  (rd_data)
  );

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = load_q ? rd_data : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random traffic
// checked against a byte-addressed little-endian memory model.
module tb_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam int          WAITS = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [1:0]  req_size = 2'd0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, resp_err, halt;
  logic [31:0] resp_rdata, tohost;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAITS),
    .MMIO_BASE   (BASE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .halt         (halt),
    .tohost       (tohost)
  );

  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned cyc_tb = 0;
  always @(posedge clk) cyc_tb <= cyc_tb + 1;

  logic [7:0]  mm [0:4*DEPTH-1];
  logic [31:0] m_tohost = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the access rules; known=0 when the value is not predictable.
  task automatic ref_apply(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata,
                           output logic err, output logic [31:0] rd, output logic known);
    logic in_win;
    int   nb;
    rd     = 32'd0;
    known  = 1'b1;
    in_win = 1'b0;
    err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
`ifdef DMEM_MMIO_EN
    in_win = (addr - BASE) < 32'd8;
    if (in_win && size != 2'd2) err = 1'b1;
`endif
    if (!in_win && (addr >> 2) >= 32'(DEPTH)) err = 1'b1;
    if (err) return;
    if (in_win) begin
      if (addr - BASE == 32'd0) begin
        if (wen) m_tohost = wdata;
        else     rd = m_tohost;
      end else if (!wen) begin
        known = 1'b0;
      end
      return;
    end
    nb = 1 << size;
    if (wen) begin
      for (int i = 0; i < nb; i++) mm[addr + 32'(i)] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < nb; i++) rd[8*i +: 8] = mm[addr + 32'(i)];
      if (!uns) for (int i = 8*nb; i < 32; i++) rd[i] = rd[8*nb-1];
    end
  endtask

  task automatic run(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                     input logic uns, input logic [31:0] wdata, input int hold, input logic eager,
                     output logic [31:0] got, output int lat, output int unsigned acc);
    logic        exp_err, known, err0;
    logic [31:0] exp_rd, rd0;
    ref_apply(wen, addr, size, uns, wdata, exp_err, exp_rd, known);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; resp_ready = eager;
    chk("req_ready_idle", req_ready, 1'b1);
    @(posedge clk);
    acc = cyc_tb;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("latency@%h", addr), 32'(lat), exp_err ? 32'd1 : 32'(1 + WAITS));
    chk($sformatf("resp_err@%h", addr), resp_err, exp_err);
    if (known) chk($sformatf("resp_rdata@%h", addr), resp_rdata, exp_rd);
    rd0 = resp_rdata; err0 = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_rdata", resp_rdata, rd0);
      chk("hold_err", resp_err, err0);
      chk("hold_req_ready", req_ready, 1'b0);
    end
    got = resp_rdata;
    $display("xact wen=%0d addr=%h size=%0d uns=%0d wdata=%h -> rdata=%h err=%0d lat=%0d",
             wen, addr, size, uns, wdata, resp_rdata, resp_err, lat);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("idle_req_ready", req_ready, 1'b1);
    chk("idle_resp_valid", resp_valid, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, c0, c1;
    int          lat;
    int unsigned acc, t0, t1;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", resp_err, 1'b0);
    chk("rst_halt", halt, 1'b0);
    chk("rst_tohost", tohost, 32'd0);
    reset = 1'b1;

    run(1'b1, 32'h00, 2'd2, 1'b0, 32'h0123_4567, 0, 1'b0, got, lat, acc);
    run(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, got, lat, acc);
    chk("tp_store_rdata", got, 32'd0);
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    chk("tp_load_word", got, 32'hDEAD_BEEF);
    chk("tp_load_lat", 32'(lat), 32'd3);
    run(1'b1, 32'h13, 2'd0, 1'b0, 32'h0000_0080, 0, 1'b0, got, lat, acc);
    run(1'b0, 32'h13, 2'd0, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    chk("tp_lb_signed", got, 32'hFFFF_FF80);
    run(1'b0, 32'h13, 2'd0, 1'b1, 32'd0, 0, 1'b0, got, lat, acc);
    chk("tp_lb_unsigned", got, 32'h0000_0080);
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    chk("tp_lw_merged", got, 32'h80AD_BEEF);
    run(1'b0, 32'h11, 2'd1, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    chk("tp_misalign_rdata", got, 32'd0);
    chk("tp_misalign_lat", 32'(lat), 32'd1);
    run(1'b1, 32'(DEPTH*4), 2'd2, 1'b0, 32'hCAFE_F00D, 0, 1'b0, got, lat, acc);
    chk("tp_oor_lat", 32'(lat), 32'd1);
    run(1'b0, 32'h00, 2'd2, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    chk("tp_oor_untouched", got, 32'h0123_4567);
    run(1'b0, 32'h10, 2'd2, 1'b0, 32'd0, 5, 1'b0, got, lat, acc);

    run(1'b1, 32'h20, 2'd2, 1'b0, 32'h1111_2222, 0, 1'b0, got, lat, acc);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h20; req_size = 2'd2; req_wdata = 32'h9999_8888;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_busy", req_ready, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_req_ready", req_ready, 1'b1);
    chk("midrst_resp_valid", resp_valid, 1'b0);
    chk("midrst_rdata", resp_rdata, 32'd0);
    chk("midrst_err", resp_err, 1'b0);
    chk("midrst_halt", halt, 1'b0);
    chk("midrst_tohost", tohost, 32'd0);
    m_tohost = 32'd0;
    reset = 1'b1;
    run(1'b0, 32'h20, 2'd2, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    chk("midrst_old_data", got, 32'h1111_2222);

    for (int k = 0; k < 16; k++) run(1'b1, 32'(k*4), 2'd2, 1'b0, $urandom, 0, 1'b0, got, lat, acc);
    for (int k = 0; k < 60; k++) begin
      logic [31:0] a;
      logic [1:0]  s;
      logic        w, u, e;
      a = ($urandom_range(0, 9) == 0) ? 32'(DEPTH*4 + $urandom_range(0, 255)) : 32'($urandom_range(0, 63));
      s = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      w = 1'($urandom_range(0, 1));
      u = 1'($urandom_range(0, 1));
      e = 1'($urandom_range(0, 1));
      run(w, a, s, u, $urandom, 0, e, got, lat, acc);
    end

`ifdef DMEM_MMIO_EN
    run(1'b1, BASE, 2'd2, 1'b0, 32'd1, 0, 1'b0, got, lat, acc);
    chk("mmio_halt", halt, 1'b1);
    chk("mmio_tohost", tohost, 32'd1);
    run(1'b0, BASE, 2'd2, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    run(1'b0, BASE + 32'd4, 2'd2, 1'b0, 32'd0, 0, 1'b0, c0, lat, t0);
    repeat (3) @(negedge clk);
    run(1'b0, BASE + 32'd4, 2'd2, 1'b0, 32'd0, 0, 1'b0, c1, lat, t1);
    chk("mmio_cycle_delta", c1 - c0, 32'(t1 - t0));
    run(1'b1, BASE + 32'd4, 2'd2, 1'b0, 32'd7, 0, 1'b0, got, lat, acc);
    run(1'b0, BASE + 32'd1, 2'd0, 1'b0, 32'd0, 0, 1'b0, got, lat, acc);
    chk("mmio_halt_sticky", halt, 1'b1);
`else
    chk("nommio_halt", halt, 1'b0);
    chk("nommio_tohost", tohost, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
